// File: rtl/aes_byte_framer_pkg.sv
// ---------------------------------------------------------------------------
// aes_frame_pkg
// Shared definitions for the AES byte framer: the framer state encoding,
// the two command bytes recognised on the receive stream, and a helper
// that picks one byte out of a 128-bit block in MSB-first order.
// ---------------------------------------------------------------------------
package aes_frame_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_KEY  = 3'd1,
    LOAD_CIPH = 3'd2,
    START     = 3'd3,
    WAIT      = 3'd4,
    SEND      = 3'd5
  } state_e;

  localparam logic [7:0] CMD_KEY    = 8'h4B;  // 'K'
  localparam logic [7:0] CMD_CIPHER = 8'h43;  // 'C'

  // Byte idx of a block, idx 0 = bits [127:120], idx 15 = bits [7:0].
  // ~idx * 8 maps 0..15 onto bit offsets 120..0.
  function automatic logic [7:0] block_byte(input logic [127:0] blk,
                                            input logic [3:0]   idx);
    logic [6:0] base;
    base = {~idx, 3'b000};
    return blk[base +: 8];
  endfunction

endpackage

// File: rtl/aes_byte_framer.sv
// ---------------------------------------------------------------------------
// aes_byte_framer
// Byte-stream front end for the AES-128 decryption controller. Collects a
// 16-byte key ('K' command) and a 16-byte ciphertext ('C' command) from the
// I2C slave, pulses start, waits for done, and streams the 16 plaintext
// bytes back out on a valid/ready interface (MSB byte first).
//
// Ports
//   clk       clock, posedge
//   rst       asynchronous active-low reset
//   rx_data   received byte          rx_valid / rx_ready  receive handshake
//   tx_data   result byte            tx_valid / tx_ready  transmit handshake
//   chave     key to the controller  cifra  ciphertext to the controller
//   start     one-cycle launch pulse
//   palavra   plaintext, valid while done = 1
//   done      decryption complete
//   busy      high whenever the framer is not IDLE
//   err       sticky error, cleared by the next accepted command byte
// ---------------------------------------------------------------------------
module aes_byte_framer
  import aes_frame_pkg::*;
#(
  parameter int NBYTES  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [127:0] chave,
  output logic [127:0] cifra,
  output logic         start,
  input  logic [127:0] palavra,
  input  logic         done,
  output logic         busy,
  output logic         err
);

  localparam int             TW       = $clog2(TIMEOUT + 1);
  localparam logic [3:0]     LAST_IDX = 4'(NBYTES - 1);
  // Abort is decided one cycle early so err appears exactly TIMEOUT cycles
  // after the start pulse.
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

  state_e         state_q,    state_d;
  logic [3:0]     idx_q,      idx_d;
  logic [TW-1:0]  tmo_q,      tmo_d;
  logic [127:0]   chave_q,    chave_d;
  logic [127:0]   cifra_q,    cifra_d;
  logic [127:0]   result_q,   result_d;
  logic           key_ok_q,   key_ok_d;
  logic           err_q,      err_d;
  logic           tx_valid_q, tx_valid_d;
  logic [7:0]     tx_data_q,  tx_data_d;
  logic           start_q,    start_d;
  logic           busy_q,     busy_d;
  logic           rx_ready_q, rx_ready_d;

  logic           rx_fire_s;
  logic           tx_fire_s;

  assign rx_fire_s = rx_valid & rx_ready_q;
  assign tx_fire_s = tx_valid_q & tx_ready;

  // Next-state and datapath decode for the framer FSM.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    chave_d    = chave_q;
    cifra_d    = cifra_q;
    result_d   = result_q;
    key_ok_d   = key_ok_q;
    err_d      = err_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;

    case (state_q)
      IDLE: begin
        if (rx_fire_s) begin
          if (rx_data == CMD_KEY) begin
            state_d  = LOAD_KEY;
            idx_d    = 4'd0;
            key_ok_d = 1'b0;
            err_d    = 1'b0;
          end else if (rx_data == CMD_CIPHER) begin
            state_d  = LOAD_CIPH;
            idx_d    = 4'd0;
            err_d    = 1'b0;
          end else begin
            err_d    = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      LOAD_KEY: begin
        if (rx_fire_s) begin
          chave_d = {chave_q[119:0], rx_data};
          if (idx_q == LAST_IDX) begin
            key_ok_d = 1'b1;
            idx_d    = 4'd0;
            state_d  = IDLE;
          end else begin
            idx_d    = idx_q + 4'd1;
          end
        end else begin
          state_d = LOAD_KEY;
        end
      end

      LOAD_CIPH: begin
        if (rx_fire_s) begin
          cifra_d = {cifra_q[119:0], rx_data};
          if (idx_q == LAST_IDX) begin
            idx_d = 4'd0;
            if (key_ok_q) begin
              state_d = START;
              tmo_d   = '0;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          state_d = LOAD_CIPH;
        end
      end

      START: begin
        // The start cycle itself counts toward the timeout.
        state_d = WAIT;
        tmo_d   = TW'(1);
      end

      WAIT: begin
        if (done) begin
          result_d   = palavra;
          tx_valid_d = 1'b1;
          tx_data_d  = block_byte(palavra, 4'd0);
          idx_d      = 4'd0;
          state_d    = SEND;
        end else if (tmo_q == TMO_LAST) begin
          err_d      = 1'b1;
          state_d    = IDLE;
        end else begin
          tmo_d      = tmo_q + TW'(1);
        end
      end

      SEND: begin
        if (tx_fire_s) begin
          if (idx_q == LAST_IDX) begin
            tx_valid_d = 1'b0;
            idx_d      = 4'd0;
            state_d    = IDLE;
          end else begin
            idx_d      = idx_q + 4'd1;
            tx_data_d  = block_byte(result_q, idx_q + 4'd1);
          end
        end else begin
          state_d = SEND;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered status outputs derived from the next state.
  always_comb begin
    start_d    = (state_d == START);
    busy_d     = (state_d != IDLE);
    rx_ready_d = (state_d == IDLE) || (state_d == LOAD_KEY) || (state_d == LOAD_CIPH);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      tmo_q      <= '0;
      chave_q    <= 128'd0;
      cifra_q    <= 128'd0;
      result_q   <= 128'd0;
      key_ok_q   <= 1'b0;
      err_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'd0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      rx_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      chave_q    <= chave_d;
      cifra_q    <= cifra_d;
      result_q   <= result_d;
      key_ok_q   <= key_ok_d;
      err_q      <= err_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  assign chave    = chave_q;
  assign cifra    = cifra_q;
  assign start    = start_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign rx_ready = rx_ready_q;

endmodule

// File: tb/tb_aes_byte_framer.sv
// ---------------------------------------------------------------------------
// tb_aes_byte_framer
// Self-checking bench for aes_byte_framer. A small stand-in for the
// decryption controller answers each start pulse with a known function of
// chave/cifra after a random delay; the bench predicts the 16 returned bytes
// from the key and ciphertext bytes it sent.
// ---------------------------------------------------------------------------
module tb_aes_byte_framer;
  import aes_frame_pkg::*;

  localparam int TIMEOUT = 1023;

  logic         clk;
  logic         rst;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [127:0] chave;
  logic [127:0] cifra;
  logic         start;
  logic [127:0] palavra;
  logic         done;
  logic         busy;
  logic         err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // stand-in controller bookkeeping
  int           start_cnt = 0;
  int           start_cyc = 0;
  logic [127:0] seen_chave = 128'd0;
  logic [127:0] seen_cifra = 128'd0;
  bit           stub_dead = 1'b0;

  // transmit side bookkeeping
  int           ready_mode = 0;
  int           rdy_cnt = 0;
  int           tx_valid_cnt = 0;
  logic [7:0]   tx_q[$];
  bit           stall_pending = 1'b0;
  logic [7:0]   stall_data = 8'd0;

  logic [127:0] model_key = 128'd0;

  aes_byte_framer #(.NBYTES(16), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .chave    (chave),
    .cifra    (cifra),
    .start    (start),
    .palavra  (palavra),
    .done     (done),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Plaintext the stand-in controller returns for a given key/ciphertext.
  function automatic logic [127:0] stub_plain(input logic [127:0] k, input logic [127:0] c);
    return k ^ {c[63:0], c[127:64]} ^ 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  endfunction

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stand-in decryption controller: one-cycle done after 1..5 cycles.
  initial begin
    done    = 1'b0;
    palavra = 128'd0;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (start === 1'b1) begin
        start_cnt++;
        start_cyc  = cyc;
        seen_chave = chave;
        seen_cifra = cifra;
        if (!stub_dead) begin
          repeat ($urandom_range(0, 4) + 1) @(negedge clk);
          palavra = stub_plain(seen_chave, seen_cifra);
          done    = 1'b1;
        end
      end
    end
  end

  // Transmit sink: drives tx_ready, collects bytes, checks stall stability.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_pending) begin
        check_eq("tx_stall_valid", 128'(tx_valid), 128'(1'b1));
        check_eq("tx_stall_data", 128'(tx_data), 128'(stall_data));
      end
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (rdy_cnt % 3 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      rdy_cnt++;
      if (tx_valid === 1'b1) begin
        tx_valid_cnt++;
        if (tx_ready) tx_q.push_back(tx_data);
        stall_pending = !tx_ready;
        stall_data    = tx_data;
      end else begin
        stall_pending = 1'b0;
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    if ($urandom_range(0, 3) == 0) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check_eq("rx_ready_wait", 128'(rx_ready), 128'(1'b1));
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] blk);
    for (int i = 0; i < 16; i++) send_byte(blk[127 - 8*i -: 8]);
  endtask

  task automatic load_key(input logic [127:0] k);
    send_byte(CMD_KEY);
    #1;
    check_eq("key_cmd_busy", 128'(busy), 128'(1'b1));
    check_eq("key_cmd_err_clear", 128'(err), 128'(1'b0));
    send_block(k);
    #1;
    check_eq("key_done_busy", 128'(busy), 128'(1'b0));
    model_key = k;
  endtask

  task automatic run_decrypt(input logic [127:0] ct, input int mode);
    int s0;
    int n;
    logic [127:0] exp;
    s0 = start_cnt;
    tx_q.delete();
    ready_mode = mode;
    send_byte(CMD_CIPHER);
    send_block(ct);
    #1;
    check_eq("start_latency", 128'(start), 128'(1'b1));
    check_eq("rx_ready_busy", 128'(rx_ready), 128'(1'b0));
    n = 0;
    while (tx_q.size() < 16 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("tx_count", 128'(tx_q.size()), 128'(16));
    check_eq("start_pulses", 128'(start_cnt - s0), 128'(1));
    check_eq("chave_at_start", seen_chave, model_key);
    check_eq("cifra_at_start", seen_cifra, ct);
    exp = stub_plain(model_key, ct);
    for (int i = 0; i < 16 && i < tx_q.size(); i++) begin
      check_eq("tx_byte", 128'(tx_q[i]), 128'(exp >> (8 * (15 - i))) & 128'hff);
    end
    @(negedge clk);
    #1;
    check_eq("end_busy", 128'(busy), 128'(1'b0));
    check_eq("end_tx_valid", 128'(tx_valid), 128'(1'b0));
    check_eq("end_err", 128'(err), 128'(1'b0));
    ready_mode = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_chave"}, chave, 128'd0);
    check_eq({tag, "_cifra"}, cifra, 128'd0);
    check_eq({tag, "_start"}, 128'(start), 128'(1'b0));
    check_eq({tag, "_tx_valid"}, 128'(tx_valid), 128'(1'b0));
    check_eq({tag, "_tx_data"}, 128'(tx_data), 128'(8'd0));
    check_eq({tag, "_err"}, 128'(err), 128'(1'b0));
    check_eq({tag, "_busy"}, 128'(busy), 128'(1'b0));
  endtask

  // Global time limit.
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]   bad;
    int           s0;
    int           v0;
    int           n;
    int           err_cyc;

    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;

    // reset state
    #19;
    check_reset_values("reset");
    #1;
    rst = 1'b1;   // t = 20, a falling edge
    @(negedge clk);

    // bad command byte: dropped, err set, still ready
    do bad = 8'($urandom_range(0, 255)); while (bad == CMD_KEY || bad == CMD_CIPHER);
    send_byte(bad);
    #1;
    check_eq("badcmd_err", 128'(err), 128'(1'b1));
    check_eq("badcmd_rx_ready", 128'(rx_ready), 128'(1'b1));
    check_eq("badcmd_busy", 128'(busy), 128'(1'b0));
    @(negedge clk);

    // key then several decrypts reusing it, varied backpressure
    load_key(rand_block());
    for (int it = 0; it < 6; it++) begin
      if (it == 3) load_key(rand_block());
      run_decrypt(rand_block(), it % 3);
    end

    // timeout: controller never answers
    stub_dead = 1'b1;
    s0 = start_cnt;
    v0 = tx_valid_cnt;
    send_byte(CMD_CIPHER);
    send_block(rand_block());
    n = 0;
    err_cyc = 0;
    while (n < TIMEOUT + 100) begin
      @(negedge clk);
      #1;
      n++;
      if (err === 1'b1) begin
        err_cyc = cyc;
        break;
      end
    end
    check_eq("tmo_err", 128'(err), 128'(1'b1));
    check_eq("tmo_start_pulses", 128'(start_cnt - s0), 128'(1));
    check_eq("tmo_latency", 128'(err_cyc - start_cyc), 128'(TIMEOUT));
    check_eq("tmo_busy", 128'(busy), 128'(1'b0));
    repeat (3) @(negedge clk);
    check_eq("tmo_no_tx", 128'(tx_valid_cnt - v0), 128'(0));
    stub_dead = 1'b0;

    // key survives the timeout
    run_decrypt(rand_block(), 2);

    // reset in the middle of a ciphertext load
    send_byte(CMD_CIPHER);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 255)));
    rst = 1'b0;
    #1;
    check_reset_values("midreset");
    check_eq("midreset_rx_ready", 128'(rx_ready), 128'(1'b1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // key discarded by reset: ciphertext frame must error out
    s0 = start_cnt;
    v0 = tx_valid_cnt;
    send_byte(CMD_CIPHER);
    send_block(rand_block());
    #1;
    check_eq("nokey_err", 128'(err), 128'(1'b1));
    check_eq("nokey_busy", 128'(busy), 128'(1'b0));
    repeat (5) @(negedge clk);
    check_eq("nokey_no_start", 128'(start_cnt - s0), 128'(0));
    check_eq("nokey_no_tx", 128'(tx_valid_cnt - v0), 128'(0));

    // full transaction after the reset
    load_key(rand_block());
    run_decrypt(rand_block(), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
